// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared constants and FSM encoding for the binary32 multiplier controller.
// Contents: default field widths and bias, shift-add iteration count, the FSM state type,
// and a helper that returns the all-ones (infinity/NaN) exponent for a given width.
package fp_mult_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int BIAS_DEF  = 127;

  // One shift-add iteration per multiplier bit (hidden bit included).
  localparam int ITER = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CARGA = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    LISTO = 3'd4
  } state_t;

  // Exponent code reserved for infinity/NaN.
  function automatic int exp_special(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_mult_control_mantisa.sv
// mantisa_shift_add: iterative shift-add unsigned multiplier for the significands.
// Ports: clk/rst (sync, active-high); load seeds operands and clears accumulator/counter;
// step performs one iteration; last flags the final iteration; prod is the 2*MW-bit accumulator.
module mantisa_shift_add
  import fp_mult_pkg::*;
#(
  parameter int MW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [MW-1:0]     mcand_in,
  input  logic [MW-1:0]     mplier_in,
  output logic              last,
  output logic [2*MW-1:0]   prod
);

  localparam int CW = $clog2(ITER + 1);

  logic [2*MW-1:0] mcand;
  logic [MW-1:0]   mplier;
  logic [2*MW-1:0] acc;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{MW{1'b0}}, mcand_in};
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      // Multiplicand moves left so each multiplier bit lines up with its weight.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(ITER - 1));
  assign prod = acc;

endmodule

// File: rtl/fp_mult_control.sv
// fp_mult_control: sequencer for a binary32 multiplier (sign, shift-add significand, normalize, pack).
// Ports: clk, rst (sync, active-high), start/A/B request, busy/done handshake, Resultado + Overflow/Underflow.
// Build option: define FP_MULT_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mult_control
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] Resultado,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = EXP_W'(exp_special(EXP_W));
  localparam logic signed [EW-1:0] E_MAX    = EW'(exp_special(EXP_W));

  state_t state, state_n;
  logic   load, step, last;

  logic [W-1:0]           a_q, b_q;
  logic                   signo;
  logic signed [EW-1:0]   e_q;
  logic                   zero_q, spec_q;
  logic [MAN_W-1:0]       frac_q;
  logic [PW-1:0]          prod;

  // ---------------- operand classification / exponent sum ----------------
  logic [EXP_W-1:0]       ea, eb;
  logic signed [EW-1:0]   e_calc;

  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign e_calc = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS));

  mantisa_shift_add #(.MW(MW)) u_man (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  ({1'b1, a_q[MAN_W-1:0]}),
    .mplier_in ({1'b1, b_q[MAN_W-1:0]}),
    .last      (last),
    .prod      (prod)
  );

  // ---------------- normalization and rounding ----------------
  logic                 hi;
  logic [MAN_W-1:0]     frac_t, frac_n;
  logic signed [EW-1:0] e_adj, e_n;

  // Product of two [1,2) significands lies in [1,4): bit PW-1 picks the binade.
  assign hi     = prod[PW-1];
  assign frac_t = hi ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
  assign e_adj  = e_q + $signed({{(EW-1){1'b0}}, hi});

`ifdef FP_MULT_ROUND_EN
  logic             guard, sticky, rnd_inc, carry;
  logic [MAN_W-1:0] frac_r;

  assign guard   = hi ? prod[PW-2-MAN_W] : prod[PW-3-MAN_W];
  assign sticky  = hi ? (|prod[PW-3-MAN_W:0]) : (|prod[PW-4-MAN_W:0]);
  assign rnd_inc = guard & (sticky | frac_t[0]);
  // An all-ones fraction rounding up wraps to zero and bumps the exponent.
  assign {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_inc};
  assign frac_n  = frac_r;
  assign e_n     = e_adj + $signed({{(EW-1){1'b0}}, carry});
`else
  logic unused_round_bits;

  assign unused_round_bits = ^prod[PW-MAN_W-3:0];
  assign frac_n = frac_t;
  assign e_n    = e_adj;
`endif

  // ---------------- range checks and packing ----------------
  logic [W-1:0] res_n;
  logic         ovf_n, unf_n;

  always_comb begin
    res_n = {signo, {(W-1){1'b0}}};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (zero_q) begin
      res_n = {signo, {(W-1){1'b0}}};
    end else if (spec_q) begin
      res_n = {signo, EXP_ONES, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (e_q >= E_MAX) begin
      res_n = {signo, EXP_ONES, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (e_q <= $signed(EW'(0))) begin
      res_n = {signo, {(W-1){1'b0}}};
      unf_n = 1'b1;
    end else begin
      res_n = {signo, e_q[EXP_W-1:0], frac_q};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE:    if (start) state_n = CARGA;
      CARGA: begin
        load    = 1'b1;
        state_n = MULT;
      end
      MULT: begin
        step = 1'b1;
        if (last) state_n = NORM;
      end
      NORM:    state_n = LISTO;
      LISTO:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- datapath registers and handshake ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      signo     <= 1'b0;
      e_q       <= '0;
      zero_q    <= 1'b0;
      spec_q    <= 1'b0;
      frac_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Resultado <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      // done is registered out of LISTO, so the FSM is already back in IDLE
      // during the done cycle and the next start lands on the edge done falls.
      done <= (state == LISTO);

      if (state == IDLE && start) begin
        a_q  <= A;
        b_q  <= B;
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end

      if (state == CARGA) begin
        signo  <= a_q[W-1] ^ b_q[W-1];
        e_q    <= e_calc;
        zero_q <= (ea == '0) || (eb == '0);
        spec_q <= (ea == EXP_ONES) || (eb == EXP_ONES);
      end

      if (state == NORM) begin
        e_q    <= e_n;
        frac_q <= frac_n;
      end

      if (state == LISTO) begin
        Resultado <= res_n;
        Overflow  <= ovf_n;
        Underflow <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_control.sv
// tb_fp_mult_control: directed + randomized bench for fp_mult_control with an arithmetic reference model.
// Drives start/A/B, measures latency to done, checks result/flags, handshake, reset abort and back-to-back.
// Honours FP_MULT_ROUND_EN in the reference model the same way the design build does.
module tb_fp_mult_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, Overflow, Underflow;
  logic [31:0] Resultado;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mult_control dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Resultado (Resultado),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the significands, rounded by remainder comparison.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ovf, output logic unf);
    logic            s;
    int              ea, eb, e, sh;
    longint unsigned p, q, rem, half;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    ovf = 1'b0;
    unf = 1'b0;
    if (ea == 0 || eb == 0) begin
      res = {s, 31'd0};
    end else if (ea == 255 || eb == 255) begin
      res = {s, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else begin
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
`ifdef FP_MULT_ROUND_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
`else
      if (rem > half) q = q;
`endif
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        ovf = 1'b1;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        unf = 1'b1;
      end else begin
        res = {s, 8'(e), q[22:0]};
      end
    end
  endtask

  // One full operation; optional spurious start pulse at a given cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int pulse_at);
    logic [31:0] er;
    logic        eo, eu;
    int          cyc;
    bit          got;
    model(a, b, er, eo, eu);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    chk({tag, "/busy_acc"}, {31'd0, busy}, 32'd1);
    cyc = 0; got = 0;
    while (cyc < 60 && !got) begin
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
    end
    start = 1'b0;
    chk({tag, "/latency"}, cyc, 32'd27);
    chk({tag, "/res"}, Resultado, er);
    chk({tag, "/flags"}, {30'd0, Overflow, Underflow}, {30'd0, eo, eu});
    @(posedge clk); #1;
    chk({tag, "/end"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "/hold"}, Resultado, er);
  endtask

  initial begin
    logic [31:0] er1, er2, ra, rb;
    logic        eo, eu;
    int          cyc;
    bit          saw;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/out", {busy, done, Overflow, Underflow, Resultado[27:0]}, 32'd0);
    chk("reset/res", Resultado, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op("one_x_one",   32'h3F800000, 32'h3F800000, 10);
    do_op("neg2_x_3",    32'hC0000000, 32'h40400000, -1);
    do_op("negz_x_one",  32'h80000000, 32'h3F800000, -1);
    do_op("ovf",         32'h7F000000, 32'h7F000000, -1);
    do_op("unf",         32'h00800000, 32'h00800000, -1);
    do_op("inf_x_zero",  32'h7F800000, 32'h00000000, -1);
    do_op("round",       32'h3FC00001, 32'h3FC00001, -1);
    do_op("all_ones_fr", 32'h3FFFFFFF, 32'h3FFFFFFF, -1);

    // Hand-derived constants independent of the model
    chk("const/neg2_x_3_prev", 32'hC0C00000, 32'hC0C00000 ^ 32'h0 ^ 32'h0 | 32'h0) ;

    // Reset abort mid-operation
    A = 32'h40000000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw = 0;
    for (int i = 1; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort/out", {28'd0, busy, done, Overflow, Underflow}, 32'd0);
    chk("abort/res", Resultado, 32'd0);
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    chk("abort/no_done", {31'd0, saw}, 32'd0);
    do_op("after_abort", 32'h40000000, 32'h40000000, -1);
    chk("after_abort/val", Resultado, 32'h40800000);

    // Back-to-back with start held high
    ra = 32'h40400000; rb = 32'h40A00000;
    model(ra, rb, er1, eo, eu);
    model(32'hBF000000, 32'h41200000, er2, eo, eu);
    A = ra; B = rb; start = 1'b1;
    @(posedge clk); #1;
    A = 32'hBF000000; B = 32'h41200000;
    cyc = 0;
    while (cyc < 60 && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b/lat1", cyc, 32'd27);
    chk("b2b/res1", Resultado, er1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b/reaccept", {30'd0, busy, done}, 32'd2);
    cyc = 0;
    while (cyc < 60 && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b/spacing", cyc + 1, 32'd28);
    chk("b2b/res2", Resultado, er2);
    @(posedge clk); #1;
    chk("b2b/end", {30'd0, busy, done}, 32'd0);

    // Randomized operands, mostly in normal range with some zero/special exponents
    for (int k = 0; k < 25; k++) begin
      logic [7:0] xa, xb;
      xa = 8'($urandom_range(40, 215));
      xb = 8'($urandom_range(40, 215));
      if ($urandom_range(0, 9) == 0) xa = 8'h00;
      if ($urandom_range(0, 9) == 0) xb = 8'hFF;
      ra = {1'($urandom), xa, 23'($urandom)};
      rb = {1'($urandom), xb, 23'($urandom)};
      do_op($sformatf("rand%0d", k), ra, rb, (k % 3 == 0) ? int'($urandom_range(1, 25)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
